// File: rtl/chacha_block_seq.sv
// ChaCha block sequencer. Loads 16 state words serially, drives an external
// half-quarter-round datapath for ROUNDS rounds, then streams out the 16
// result words. The result can optionally include the input feed-forward.
module chacha_block_seq #(
   parameter int unsigned ROUNDS      = 20,
   parameter bit          FEEDFORWARD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        qr_sel,
   output logic [31:0] qr_a,
   output logic [31:0] qr_b,
   output logic [31:0] qr_c,
   output logic [31:0] qr_d,
   input  logic [31:0] qr_a_res,
   input  logic [31:0] qr_b_res,
   input  logic [31:0] qr_c_res,
   input  logic [31:0] qr_d_res
);

   localparam int unsigned RCW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

   typedef enum logic [1:0] {
      S_LOAD,
      S_RUN,
      S_OUT
   } state_t;

   state_t           r_state;
   logic [31:0]      r_st  [16];
   logic [31:0]      r_org [16];
   logic [3:0]       r_wcnt;
   logic [1:0]       r_qidx;
   logic             r_half;
   logic [RCW-1:0]   r_rcnt;

   logic             w_diag;
   logic [3:0]       w_idx0;
   logic [3:0]       w_idx1;
   logic [3:0]       w_idx2;
   logic [3:0]       w_idx3;
   logic [31:0]      w_ff_add;

   // Word indices of the current quarter-round: odd rounds rotate rows 1..3
   // by 1..3 lanes to form the diagonals; 2-bit lane arithmetic wraps mod 4.
   always_comb begin
      w_diag = r_rcnt[0];
      w_idx0 = {2'b00, r_qidx};
      w_idx1 = {2'b01, r_qidx + (w_diag ? 2'd1 : 2'd0)};
      w_idx2 = {2'b10, r_qidx + (w_diag ? 2'd2 : 2'd0)};
      w_idx3 = {2'b11, r_qidx + (w_diag ? 2'd3 : 2'd0)};
   end

   // Output decode from the state register; datapath operands only in RUN.
   always_comb begin
      in_ready  = (r_state == S_LOAD);
      out_valid = (r_state == S_OUT);
      busy      = (r_state == S_RUN);
      qr_sel    = 1'b0;
      qr_a      = '0;
      qr_b      = '0;
      qr_c      = '0;
      qr_d      = '0;
      w_ff_add  = FEEDFORWARD ? r_org[r_wcnt] : '0;
      out_data  = '0;
      if (r_state == S_RUN) begin
         qr_sel = r_half;
         qr_a   = r_st[w_idx0];
         qr_b   = r_st[w_idx1];
         qr_c   = r_st[w_idx2];
         qr_d   = r_st[w_idx3];
      end
      if (r_state == S_OUT) begin
         out_data = r_st[r_wcnt] + w_ff_add;
      end
   end

   // Load / run / output sequencing and working-state update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_LOAD;
         r_wcnt  <= '0;
         r_qidx  <= '0;
         r_half  <= 1'b0;
         r_rcnt  <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            r_st[i]  <= '0;
            r_org[i] <= '0;
         end
      end else begin
         case (r_state)
            S_LOAD: begin
               if (in_valid) begin
                  r_st[r_wcnt] <= in_data;
                  if (FEEDFORWARD) begin
                     r_org[r_wcnt] <= in_data;
                  end
                  r_wcnt <= r_wcnt + 4'd1;
                  if (r_wcnt == 4'd15) begin
                     r_state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               r_st[w_idx0] <= qr_a_res;
               r_st[w_idx1] <= qr_b_res;
               r_st[w_idx2] <= qr_c_res;
               r_st[w_idx3] <= qr_d_res;
               if (!r_half) begin
                  r_half <= 1'b1;
               end else begin
                  r_half <= 1'b0;
                  r_qidx <= r_qidx + 2'd1;
                  if (r_qidx == 2'd3) begin
                     if (r_rcnt == RCW'(ROUNDS - 1)) begin
                        r_rcnt  <= '0;
                        r_state <= S_OUT;
                     end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                     end
                  end
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_wcnt <= r_wcnt + 4'd1;
                  if (r_wcnt == 4'd15) begin
                     r_state <= S_LOAD;
                  end
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_block_seq.sv
// Bench for chacha_block_seq: two instances (feed-forward on and off) run in
// lockstep, each wired to a behavioural half-quarter-round stand-in.
module tb_chacha_block_seq;

   localparam int ROUNDS = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        d0_in_ready, d0_out_valid, d0_busy, d0_qr_sel;
   logic [31:0] d0_out_data, d0_qa, d0_qb, d0_qc, d0_qd, d0_ar, d0_br, d0_cr, d0_dr;
   logic        d1_in_ready, d1_out_valid, d1_busy, d1_qr_sel;
   logic [31:0] d1_out_data, d1_qa, d1_qb, d1_qc, d1_qd, d1_ar, d1_br, d1_cr, d1_dr;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] vec    [16];
   logic [31:0] exp_ff [16];
   logic [31:0] exp_nf [16];
   logic [31:0] got0   [16];
   logic [31:0] got1   [16];
   logic [31:0] m_x    [16];
   logic [31:0] sh     [16];

   logic [31:0] rfc_in [16] = '{
      32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
      32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
   logic [31:0] rfc_out [16] = '{
      32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

   // Quarter-round word groups: [0]=column round, [1]=diagonal round.
   int sched [2][4][4] = '{
      '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}},
      '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}}};

   always #5 clk = ~clk;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Stand-in for the external chacha_qr: one half of a quarter-round.
   function automatic logic [127:0] qr_half(input logic sel, input logic [31:0] a, b, c, d);
      logic [31:0] na, nb, nc, nd;
      na = a + b;
      nd = rotl(d ^ na, sel ? 8 : 16);
      nc = c + nd;
      nb = rotl(b ^ nc, sel ? 7 : 12);
      return {na, nb, nc, nd};
   endfunction

   assign {d0_ar, d0_br, d0_cr, d0_dr} = qr_half(d0_qr_sel, d0_qa, d0_qb, d0_qc, d0_qd);
   assign {d1_ar, d1_br, d1_cr, d1_dr} = qr_half(d1_qr_sel, d1_qa, d1_qb, d1_qc, d1_qd);

   chacha_block_seq #(.ROUNDS(ROUNDS), .FEEDFORWARD(1'b1)) u_dut_ff (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d0_in_ready), .in_data(in_data),
      .out_valid(d0_out_valid), .out_ready(out_ready), .out_data(d0_out_data), .busy(d0_busy),
      .qr_sel(d0_qr_sel), .qr_a(d0_qa), .qr_b(d0_qb), .qr_c(d0_qc), .qr_d(d0_qd),
      .qr_a_res(d0_ar), .qr_b_res(d0_br), .qr_c_res(d0_cr), .qr_d_res(d0_dr));

   chacha_block_seq #(.ROUNDS(ROUNDS), .FEEDFORWARD(1'b0)) u_dut_nf (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready), .in_data(in_data),
      .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data), .busy(d1_busy),
      .qr_sel(d1_qr_sel), .qr_a(d1_qa), .qr_b(d1_qb), .qr_c(d1_qc), .qr_d(d1_qd),
      .qr_a_res(d1_ar), .qr_b_res(d1_br), .qr_c_res(d1_cr), .qr_d_res(d1_dr));

   // ---------------- reference model (whole-block ChaCha) ----------------
   task automatic ref_qr(input int a, input int b, input int c, input int d);
      m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 16);
      m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 12);
      m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 8);
      m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 7);
   endtask

   task automatic ref_block();
      for (int i = 0; i < 16; i++) m_x[i] = vec[i];
      for (int r = 0; r < ROUNDS; r += 2) begin
         ref_qr(0, 4, 8, 12);  ref_qr(1, 5, 9, 13);  ref_qr(2, 6, 10, 14); ref_qr(3, 7, 11, 15);
         ref_qr(0, 5, 10, 15); ref_qr(1, 6, 11, 12); ref_qr(2, 7, 8, 13);  ref_qr(3, 4, 9, 14);
      end
      for (int i = 0; i < 16; i++) begin
         exp_nf[i] = m_x[i];
         exp_ff[i] = m_x[i] + vec[i];
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive_noise(input int noise);
      if (noise == 0) in_valid = 1'b0;
      else if (noise == 1) in_valid = 1'($urandom_range(0, 1));
      else in_valid = 1'b1;
      in_data = $urandom;
   endtask

   // Presents vec[0..upto-1]; returns right after the accept edge of the last word.
   task automatic load_words(input bit gaps, input int upto);
      for (int i = 0; i < upto; i++) begin
         @(negedge clk);
         if (gaps) begin
            int ng;
            ng = $urandom_range(0, 3);
            repeat (ng) begin
               in_valid = 1'b0;
               in_data  = $urandom;
               @(negedge clk);
            end
         end
         n_vec++;
         if (d0_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_ready word %0d: in_ready=%b required 1", i, d0_in_ready);
         end
         in_valid = 1'b1;
         in_data  = vec[i];
      end
      @(posedge clk);
   endtask

   // Follows RUN cycle by cycle, checking the datapath operands against a
   // shadow state advanced with the round schedule. Returns at first out_valid
   // (or after stop_after busy cycles when stop_after > 0).
   task automatic monitor_run(input int noise, input int stop_after,
                              output int busy_cnt, output int first_out, output bit tmo);
      for (int i = 0; i < 16; i++) sh[i] = vec[i];
      busy_cnt = 0; first_out = -1; tmo = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (d0_out_valid) begin
            first_out = n; tmo = 1'b0;
            break;
         end
         if (d0_busy) begin
            int t, k, h, i0, i1, i2, i3;
            h  = busy_cnt % 2;
            k  = (busy_cnt / 2) % 4;
            t  = (busy_cnt / 8) % 2;
            i0 = sched[t][k][0]; i1 = sched[t][k][1]; i2 = sched[t][k][2]; i3 = sched[t][k][3];
            n_vec++;
            if (d0_qr_sel !== 1'(h) || d1_qr_sel !== 1'(h) ||
                d0_qa !== sh[i0] || d0_qb !== sh[i1] || d0_qc !== sh[i2] || d0_qd !== sh[i3] ||
                d1_qa !== sh[i0] || d1_qd !== sh[i3]) begin
               n_err++;
               $display("FAIL schedule cycle %0d: sel=%b a=%h b=%h c=%h d=%h required sel=%0d a=%h b=%h c=%h d=%h (words %0d,%0d,%0d,%0d)",
                        busy_cnt, d0_qr_sel, d0_qa, d0_qb, d0_qc, d0_qd, h,
                        sh[i0], sh[i1], sh[i2], sh[i3], i0, i1, i2, i3);
            end
            {sh[i0], sh[i1], sh[i2], sh[i3]} = qr_half(1'(h), sh[i0], sh[i1], sh[i2], sh[i3]);
            busy_cnt++;
            if (stop_after > 0 && busy_cnt >= stop_after) begin
               tmo = 1'b0;
               break;
            end
         end
         drive_noise(noise);
      end
   endtask

   // Takes nwords result words into got0/got1, optionally stalling 0-5 cycles.
   task automatic collect_out(input bit stalls, input int noise, input int nwords,
                              output int cycles, output int unstable, output bit tmo);
      logic [31:0] hold0, hold1;
      cycles = 0; unstable = 0; tmo = 1'b0;
      for (int k = 0; k < nwords; k++) begin
         int w;
         w = 0;
         while (!d0_out_valid && w < 20) begin
            @(negedge clk); cycles++; w++;
         end
         if (!d0_out_valid) begin
            tmo = 1'b1;
            break;
         end
         if (stalls) begin
            int ns;
            ns = $urandom_range(0, 5);
            out_ready = 1'b0;
            hold0 = d0_out_data;
            hold1 = d1_out_data;
            repeat (ns) begin
               drive_noise(noise);
               @(negedge clk); cycles++;
               if (!d0_out_valid || d0_out_data !== hold0 || d1_out_data !== hold1) unstable++;
            end
         end
         got0[k]   = d0_out_data;
         got1[k]   = d1_out_data;
         out_ready = 1'b1;
         drive_noise(noise);
         @(negedge clk); cycles++;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_block(input bit gaps, input int noise, input bit stalls,
                            output int busy_cnt, output int first_out, output int cycles,
                            output int unstable, output bit tmo);
      bit t1, t2;
      ref_block();
      load_words(gaps, 16);
      monitor_run(noise, 0, busy_cnt, first_out, t1);
      t2 = 1'b0;
      if (!t1) collect_out(stalls, noise, 16, cycles, unstable, t2);
      tmo = t1 | t2;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      hold_reset();
      @(negedge clk);
      n_vec++;
      if (d0_in_ready !== 1'b1 || d0_out_valid !== 1'b0 || d0_busy !== 1'b0 || d0_qr_sel !== 1'b0 ||
          d0_qa !== 32'h0 || d0_qb !== 32'h0 || d0_qc !== 32'h0 || d0_qd !== 32'h0 || d0_out_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_ff: rdy=%b ov=%b busy=%b sel=%b qa=%h qd=%h od=%h required 1 0 0 0 0 0 0",
                  d0_in_ready, d0_out_valid, d0_busy, d0_qr_sel, d0_qa, d0_qd, d0_out_data);
      end
      n_vec++;
      if (d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0 || d1_busy !== 1'b0 || d1_out_data !== 32'h0) begin
         n_err++;
         $display("FAIL reset_nf: rdy=%b ov=%b busy=%b od=%h required 1 0 0 0",
                  d1_in_ready, d1_out_valid, d1_busy, d1_out_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_rfc();
      int bc, fo, cy, us; bit tmo;
      for (int i = 0; i < 16; i++) vec[i] = rfc_in[i];
      run_block(1'b0, 0, 1'b0, bc, fo, cy, us, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL rfc_timeout: block did not complete"); end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (got0[i] !== rfc_out[i]) begin
            n_err++; $display("FAIL rfc_ff word %0d: got %h required %h", i, got0[i], rfc_out[i]);
         end
         n_vec++;
         if (got1[i] !== exp_nf[i]) begin
            n_err++; $display("FAIL rfc_nf word %0d: got %h required %h", i, got1[i], exp_nf[i]);
         end
      end
      n_vec++;
      if (got1[0] !== 32'h837778ab) begin
         n_err++; $display("FAIL rfc_nf_word0: got %h required 837778ab", got1[0]);
      end
   endtask

   task automatic test_zero();
      int bc, fo, cy, us; bit tmo;
      for (int i = 0; i < 16; i++) vec[i] = '0;
      run_block(1'b0, 0, 1'b0, bc, fo, cy, us, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL zero_timeout: block did not complete"); end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (got0[i] !== 32'h0 || got1[i] !== 32'h0) begin
            n_err++; $display("FAIL zero word %0d: got ff=%h nf=%h required 0", i, got0[i], got1[i]);
         end
      end
   endtask

   task automatic test_timing();
      int bc, fo, cy, us; bit tmo;
      for (int i = 0; i < 16; i++) vec[i] = rfc_in[i];
      out_ready = 1'b1;
      run_block(1'b0, 2, 1'b0, bc, fo, cy, us, tmo);
      n_vec++;
      if (tmo) begin n_err++; $display("FAIL timing_timeout: block did not complete"); end
      n_vec++;
      if (bc !== ROUNDS * 8) begin n_err++; $display("FAIL timing_busy: busy cycles %0d required %0d", bc, ROUNDS * 8); end
      n_vec++;
      if (fo !== ROUNDS * 8) begin n_err++; $display("FAIL timing_latency: out_valid after edge E0+%0d required E0+%0d", fo, ROUNDS * 8); end
      n_vec++;
      if (cy !== 16) begin n_err++; $display("FAIL timing_beats: 16 words took %0d cycles required 16", cy); end
      n_vec++;
      if (d0_in_ready !== 1'b1 || d0_busy !== 1'b0 || d0_out_valid !== 1'b0) begin
         n_err++; $display("FAIL timing_reload: rdy=%b busy=%b ov=%b required 1 0 0", d0_in_ready, d0_busy, d0_out_valid);
      end
      n_vec++;
      if (got0[15] !== rfc_out[15]) begin n_err++; $display("FAIL timing_word15: got %h required %h", got0[15], rfc_out[15]); end
   endtask

   task automatic test_backpressure();
      int bc, fo, cy, us; bit tmo;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) vec[i] = (t == 0) ? rfc_in[i] : $urandom;
         run_block(1'b1, 1, 1'b1, bc, fo, cy, us, tmo);
         n_vec++;
         if (tmo) begin n_err++; $display("FAIL bp_timeout block %0d: did not complete", t); end
         n_vec++;
         if (us !== 0) begin n_err++; $display("FAIL bp_stable block %0d: %0d unstable stall cycles required 0", t, us); end
         for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got0[i] !== exp_ff[i] || got1[i] !== exp_nf[i]) begin
               n_err++;
               $display("FAIL bp_word blk %0d word %0d: got ff=%h nf=%h required ff=%h nf=%h",
                        t, i, got0[i], got1[i], exp_ff[i], exp_nf[i]);
            end
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_schedule();
      int bc, fo, cy, us; bit tmo;
      for (int i = 0; i < 16; i++) vec[i] = $urandom;
      run_block(1'b0, 1, 1'b0, bc, fo, cy, us, tmo);
      n_vec++;
      if (tmo || bc !== ROUNDS * 8) begin
         n_err++; $display("FAIL sched_len: busy cycles %0d timeout %b required %0d and 0", bc, tmo, ROUNDS * 8);
      end
      n_vec++;
      if (d0_qr_sel !== 1'b0 || d0_qa !== 32'h0 || d0_qd !== 32'h0) begin
         n_err++; $display("FAIL sched_idle: sel=%b qa=%h qd=%h required 0 0 0", d0_qr_sel, d0_qa, d0_qd);
      end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (got0[i] !== exp_ff[i]) begin
            n_err++; $display("FAIL sched_word %0d: got %h required %h", i, got0[i], exp_ff[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int bc, fo, cy, us, seen; bit tmo;
      for (int phase = 0; phase < 3; phase++) begin
         for (int i = 0; i < 16; i++) vec[i] = rfc_in[i];
         if (phase == 0) begin
            load_words(1'b0, 7);
         end else begin
            load_words(1'b0, 16);
            monitor_run(0, (phase == 1) ? 50 : 0, bc, fo, tmo);
            if (phase == 2) collect_out(1'b0, 0, 5, cy, us, tmo);
         end
         hold_reset();
         n_vec++;
         if (d0_in_ready !== 1'b1 || d0_busy !== 1'b0 || d0_out_valid !== 1'b0 ||
             d1_in_ready !== 1'b1 || d1_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_flags phase %0d: rdy=%b busy=%b ov=%b required 1 0 0",
                     phase, d0_in_ready, d0_busy, d0_out_valid);
         end
         rst_n = 1'b1;
         out_ready = 1'b1;
         seen = 0;
         repeat (20) begin
            @(negedge clk);
            if (d0_out_valid || d0_busy) seen++;
         end
         n_vec++;
         if (seen !== 0) begin n_err++; $display("FAIL abort_quiet phase %0d: %0d active cycles required 0", phase, seen); end
         run_block(1'b0, 0, 1'b0, bc, fo, cy, us, tmo);
         n_vec++;
         if (tmo) begin n_err++; $display("FAIL abort_reload_timeout phase %0d", phase); end
         for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got0[i] !== rfc_out[i]) begin
               n_err++; $display("FAIL abort_reload phase %0d word %0d: got %h required %h", phase, i, got0[i], rfc_out[i]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_rfc();
      test_zero();
      test_timing();
      test_backpressure();
      test_schedule();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
